load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory bus: accepts one load/store request at a time from the pipeline MEM stage.
- Drives word-aligned address, read-enable, write-enable and the shared tri-state 32-bit data bus toward `data_memory`.
- Handles byte/half/word access with sign/zero extension on loads.
- Sub-word stores are done as read-modify-write, because memory writes are whole-word only.

Parameters:
ADDR_WIDTH, constants::ADDR_WIDTH, byte-address width of request and memory address.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  unit can accept request (IDLE only)
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  mem_size_t: 00 byte, 01 half, 10 word
req_unsigned_i  input  1  zero-extend load (LBU/LHU)
req_addr_i  input  ADDR_WIDTH  byte address
req_wdata_i  input  32  store data, right-aligned
resp_valid_o  output  1  one-cycle completion pulse
resp_rdata_o  output  32  extended load data, held until next response
resp_err_o  output  1  misaligned access, valid with resp_valid_o
mem_addr_o  output  ADDR_WIDTH  word-aligned address (low 2 bits 0)
mem_bus_io  inout  32  shared tri-state data bus
mem_re_o  output  1  memory read enable
mem_we_o  output  1  memory write enable

Behaviour:
- Reset (async):
  - state=IDLE; resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - mem_re_o=0, mem_we_o=0, mem_addr_o=0; mem_bus_io released ('z).
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE:
  - req_ready_o=1; handshake on req_valid_i&&req_ready_o latches all req fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1; no bus cycle.
  - Otherwise: load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
- LOAD:
  - mem_re_o=1.
  - Memory read is combinational; sample mem_bus_io at posedge.
  - Select lane by addr[1:0] (little-endian), sign- or zero-extend into resp_rdata_o -> RESP.
- RMW_RD:
  - mem_re_o=1; sample the word.
  - Merge req_wdata low byte/half into lane addr[1:0] into the merge register -> STORE.
- STORE:
  - mem_we_o=1; drive mem_bus_io with the merge register (sub-word) or req_wdata (word).
  - Memory captures at this posedge -> RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle -> IDLE.
  - No response backpressure; next request is accepted the cycle after RESP.
- Latency, acceptance edge to resp_valid_o high:
  - load 2 cycles;
  - word store 2 cycles;
  - sub-word store 3 cycles;
  - misaligned 1 cycle.
- Bus exclusivity:
  - mem_re_o and mem_we_o are never high together.
  - The unit drives mem_bus_io only in STORE, 'z otherwise, so no contention with the memory's read drive.
- mem_addr_o = {latched addr[ADDR_WIDTH-1:2], 2'b00} in LOAD/RMW_RD/STORE, holds last value otherwise.
- Stores leave resp_rdata_o unchanged.
- req_size_i=11 is treated as word.
- Reset mid-operation: FSM returns to IDLE immediately, enables drop asynchronously, bus released; no partial write occurs.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: misaligned requests produce resp_err_o=1 with no memory access, as above.
- Undefined:
  - resp_err_o is tied 0.
  - The address is force-aligned: half uses addr[1], word ignores addr[1:0].
  - The access proceeds normally.

Decomposition:
- constants package additions:
  - mem_size_t enum (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10);
  - lsu_state_t enum.
- Sub-module lsu_byte_lane (combinational):
  - load extract/extend: word, offset, size, unsigned -> data;
  - store merge: old word, wdata, offset, size -> new word.
- FSM, registers and tri-state driver stay in load_store_unit.

Test Plan:
- Mem[0x10]=0x8899AABB, LB addr 0x13 -> resp 0xFFFFFF88, err=0, resp_valid 2 cycles after acceptance.
- Same word, LBU 0x12 -> 0x00000099; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
- SB 0x11 wdata 0x12345655:
  - one re cycle then one we cycle at mem_addr 0x10, bus driven 0x889955BB only in the we cycle;
  - a later LW 0x10 returns 0x889955BB.
- SW 0x20 wdata 0xDEADBEEF:
  - no re cycle, single we cycle;
  - LW 0x20 -> 0xDEADBEEF;
  - re/we never high together and bus 'z outside STORE throughout.
- With LSU_MISALIGN_CHECK_EN, LW 0x21 -> resp 1 cycle after acceptance, err=1, no re/we. Without the macro, LW 0x21 reads word 0x20 with err=0.
- Assert rst during the RMW_RD cycle of SB 0x11:
  - mem_we_o never asserts, memory unchanged (0x8899AABB);
  - req_ready_o=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the bus address width.
// Read by load_store_unit.sv, which also honours the LSU_MISALIGN_CHECK_EN build option.
package load_store_unit_pkg;

  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_LOAD   = 3'd1,
    LSU_RMW_RD = 3'd2,
    LSU_STORE  = 3'd3,
    LSU_RESP   = 3'd4
  } lsu_state_t;

  // The unused 2'b11 size encoding behaves as a full word.
  function automatic mem_size_t norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SIZE_WORD : mem_size_t'(s);
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Combinational lane logic: load extraction with sign/zero extension and sub-word store merge
// (little-endian lanes, byte offset within the 32-bit word).
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [31:0]        shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] sext_b;
  logic signed [31:0] sext_h;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    sext_b  = lane_b;
    sext_h  = lane_h;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}  : sext_b;
      SIZE_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]} : sext_h;
      default:   load_data = word;
    endcase
  end

  // Half stores only ever land on lane 0 or lane 2, so offset[0] is ignored there.
  always_comb begin
    merge_word = word;
    case (size)
      SIZE_BYTE: merge_word[{offset, 3'b000} +: 8]        = wdata[7:0];
      SIZE_HALF: merge_word[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
      default:   merge_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores as read-modify-write.
// Build option LSU_MISALIGN_CHECK_EN: flag misaligned accesses instead of force-aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = load_store_unit_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  inout  wire  [31:0]           mem_bus_io,
  output logic                  mem_re_o,
  output logic                  mem_we_o
);

  lsu_state_t            state_q, state_d;
  mem_size_t             req_size, size_q;
  logic                  uns_q;
  logic [1:0]            req_off, off_q;
  logic [31:0]           wdata_q, merge_q, resp_rdata_q, store_data;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           load_data, merge_word;
  logic                  accept, misaligned;

  assign req_size = norm_size(req_size_i);
  assign accept   = req_valid_i && (state_q == LSU_IDLE);

  // Lane offset is force-aligned to the access size; with the check enabled the
  // misaligned cases never reach the bus, so the same offset serves both builds.
  always_comb begin
    case (req_size)
      SIZE_BYTE: req_off = req_addr_i[1:0];
      SIZE_HALF: req_off = {req_addr_i[1], 1'b0};
      default:   req_off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;

  assign misaligned = ((req_size == SIZE_HALF) && req_addr_i[0]) ||
                      ((req_size == SIZE_WORD) && (req_addr_i[1:0] != 2'b00));
  assign resp_err_o = (state_q == LSU_RESP) && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid_i) begin
          if (misaligned)                state_d = LSU_RESP;
          else if (!req_we_i)            state_d = LSU_LOAD;
          else if (req_size == SIZE_WORD) state_d = LSU_STORE;
          else                           state_d = LSU_RMW_RD;
        end
      end
      LSU_LOAD:   state_d = LSU_RESP;
      LSU_RMW_RD: state_d = LSU_STORE;
      LSU_STORE:  state_d = LSU_RESP;
      LSU_RESP:   state_d = LSU_IDLE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      mem_addr_q   <= '0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept && !misaligned)
        mem_addr_q <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
      if (state_q == LSU_LOAD)
        resp_rdata_q <= load_data;
    end
  end

  // Request payload and merge word: datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_q  <= req_size;
      uns_q   <= req_unsigned_i;
      off_q   <= req_off;
      wdata_q <= req_wdata_i;
    end
    if (state_q == LSU_RMW_RD)
      merge_q <= merge_word;
  end

  lsu_byte_lane u_lane (
    .word        (mem_bus_io),
    .wdata       (wdata_q),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merge_word  (merge_word)
  );

  // Enables and bus drive decode straight from state, so reset drops them asynchronously.
  assign store_data   = (size_q == SIZE_WORD) ? wdata_q : merge_q;
  assign mem_bus_io   = (state_q == LSU_STORE) ? store_data : 32'bz;
  assign mem_re_o     = (state_q == LSU_LOAD) || (state_q == LSU_RMW_RD);
  assign mem_we_o     = (state_q == LSU_STORE);
  assign mem_addr_o   = mem_addr_q;
  assign req_ready_o  = (state_q == LSU_IDLE);
  assign resp_valid_o = (state_q == LSU_RESP);
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a combinational-read word memory on the tri-state bus.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int AW = ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [1:0]    req_size_i = 2'b00;
  logic          req_unsigned_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [31:0]   req_wdata_i = 32'h0;
  logic          resp_valid_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;
  logic [AW-1:0] mem_addr_o;
  wire  [31:0]   mem_bus_io;
  logic          mem_re_o;
  logic          mem_we_o;

  logic [31:0]   mem [0:63];
  logic          ld_en = 1'b0;
  logic [5:0]    ld_idx = 6'd0;
  logic [31:0]   ld_val = 32'h0;

  int checks = 0;
  int errors = 0;
  int re_total = 0;
  int we_total = 0;
  int both_viol = 0;
  int bus_viol = 0;
  logic [31:0]   we_bus = 32'h0;
  logic [AW-1:0] we_addr = '0;
  logic [AW-1:0] re_addr = '0;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_bus_io     (mem_bus_io),
    .mem_re_o       (mem_re_o),
    .mem_we_o       (mem_we_o)
  );

  always #5 clk = ~clk;

  assign mem_bus_io = mem_re_o ? mem[mem_addr_o[7:2]] : 32'bz;

  always @(posedge clk) begin
    if (ld_en)         mem[ld_idx] <= ld_val;
    else if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_bus_io;
  end

  // Bus monitor; an undriven bus reads as z in 4-state simulators and 0 in 2-state ones.
  always @(negedge clk) begin
    if (mem_re_o && mem_we_o) both_viol <= both_viol + 1;
    if (mem_re_o) begin
      re_total <= re_total + 1;
      re_addr  <= mem_addr_o;
      if (mem_bus_io !== mem[mem_addr_o[7:2]]) bus_viol <= bus_viol + 1;
    end else if (!mem_we_o) begin
      if (!((mem_bus_io === 32'bz) || (mem_bus_io === 32'h0))) bus_viol <= bus_viol + 1;
    end
    if (mem_we_o) begin
      we_total <= we_total + 1;
      we_bus   <= mem_bus_io;
      we_addr  <= mem_addr_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = idx;
    ld_val = val;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  // Issues one request and waits for its response; latency counts edges from acceptance.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int nre, output int nwe);
    int g;
    int re0;
    int we0;
    g = 0;
    @(negedge clk);
    while (!req_ready_o && g < 10) begin
      @(negedge clk);
      g++;
    end
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk);
    re0 = re_total;
    we0 = we_total;
    #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = resp_rdata_o;
    err   = resp_err_o;
    @(negedge clk);
    nre = re_total - re0;
    nwe = we_total - we0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nre;
    int          nwe;
    int          we_snap;

    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready_o}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    check("rst_rdata", resp_rdata_o, 32'h0);
    check("rst_err", {31'h0, resp_err_o}, 32'h0);
    check("rst_re_we", {30'h0, mem_re_o, mem_we_o}, 32'h0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'h0);
    rst = 1'b0;

    poke(6'd4, 32'h8899AABB);

    do_req(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, lat, rd, er, nre, nwe);
    check("lb_13_data", rd, 32'hFFFFFF88);
    check("lb_13_err", {31'h0, er}, 32'h0);
    check("lb_13_lat", 32'(lat), 32'd2);
    check("lb_13_re_cycles", 32'(nre), 32'd1);

    do_req(1'b0, 2'b00, 1'b1, 16'h0012, 32'h0, lat, rd, er, nre, nwe);
    check("lbu_12_data", rd, 32'h00000099);
    do_req(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, lat, rd, er, nre, nwe);
    check("lh_12_data", rd, 32'hFFFF8899);
    do_req(1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, lat, rd, er, nre, nwe);
    check("lhu_10_data", rd, 32'h0000AABB);

    do_req(1'b1, 2'b00, 1'b0, 16'h0011, 32'h12345655, lat, rd, er, nre, nwe);
    check("sb_11_lat", 32'(lat), 32'd3);
    check("sb_11_re_cycles", 32'(nre), 32'd1);
    check("sb_11_we_cycles", 32'(nwe), 32'd1);
    check("sb_11_re_addr", 32'(re_addr), 32'h10);
    check("sb_11_we_addr", 32'(we_addr), 32'h10);
    check("sb_11_we_bus", we_bus, 32'h889955BB);
    check("sb_11_rdata_held", rd, 32'h0000AABB);
    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, lat, rd, er, nre, nwe);
    check("lw_10_after_sb", rd, 32'h889955BB);

    do_req(1'b1, 2'b10, 1'b0, 16'h0020, 32'hDEADBEEF, lat, rd, er, nre, nwe);
    check("sw_20_lat", 32'(lat), 32'd2);
    check("sw_20_re_cycles", 32'(nre), 32'd0);
    check("sw_20_we_cycles", 32'(nwe), 32'd1);
    check("sw_20_we_bus", we_bus, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, lat, rd, er, nre, nwe);
    check("lw_20", rd, 32'hDEADBEEF);
    do_req(1'b0, 2'b11, 1'b0, 16'h0020, 32'h0, lat, rd, er, nre, nwe);
    check("lw_20_size11", rd, 32'hDEADBEEF);

    do_req(1'b1, 2'b01, 1'b0, 16'h0022, 32'hCAFE1234, lat, rd, er, nre, nwe);
    check("sh_22_we_bus", we_bus, 32'h1234BEEF);
    do_req(1'b0, 2'b01, 1'b1, 16'h0022, 32'h0, lat, rd, er, nre, nwe);
    check("lhu_22", rd, 32'h00001234);
    do_req(1'b1, 2'b10, 1'b0, 16'h0020, 32'hDEADBEEF, lat, rd, er, nre, nwe);

    do_req(1'b0, 2'b10, 1'b0, 16'h0021, 32'h0, lat, rd, er, nre, nwe);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw_21_lat", 32'(lat), 32'd1);
    check("lw_21_err", {31'h0, er}, 32'h1);
    check("lw_21_bus_cycles", 32'(nre + nwe), 32'd0);
`else
    check("lw_21_lat", 32'(lat), 32'd2);
    check("lw_21_err", {31'h0, er}, 32'h0);
    check("lw_21_data", rd, 32'hDEADBEEF);
`endif

    poke(6'd4, 32'h8899AABB);
    @(negedge clk);
    we_snap = we_total;
    req_valid_i    = 1'b1;
    req_we_i       = 1'b1;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = 16'h0011;
    req_wdata_i    = 32'h12345655;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("rmw_rd_re", {31'h0, mem_re_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_re_we", {30'h0, mem_re_o, mem_we_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_after_ready", {31'h0, req_ready_o}, 32'h1);
    check("rst_after_rdata", resp_rdata_o, 32'h0);
    @(negedge clk);
    check("rst_no_we", 32'(we_total - we_snap), 32'd0);
    check("rst_mem_intact", mem[4], 32'h8899AABB);

    check("re_we_exclusive", 32'(both_viol), 32'd0);
    check("bus_release", 32'(bus_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
